// File: rtl/mem_ctrl.sv
// Handshaked memory controller: owns the RAM array, decodes the in-range window, inserts WAIT_STATES.
// Optional error output enabled by defining MEM_CTRL_ERR_EN.
module mem_ctrl #(
  parameter int          DATA_W      = 16,
  parameter int          ADDR_W      = 9,
  parameter int          RAM_AW      = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [1:0]  MREAD       = 2'b01,
  parameter logic [1:0]  MWRITE      = 2'b10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_req,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              mem_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
`ifdef MEM_CTRL_ERR_EN
  ,
  output logic              mem_err
`endif
);

  localparam int         DEPTH     = 1 << RAM_AW;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [1:0]        cmd_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic [DATA_W-1:0] ram [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic [1:0]        acc_cmd;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [RAM_AW-1:0] acc_idx;
  logic              acc_in_range;
  logic              acc_known;
  logic              ram_we;

  assign accept = (state_reg == S_IDLE) && mem_req;

  // With zero wait states the access happens on the accepting edge, before the latches are loaded.
  assign acc_cmd      = (state_reg == S_IDLE) ? mem_cmd    : cmd_reg;
  assign acc_addr     = (state_reg == S_IDLE) ? mem_addr   : addr_reg;
  assign acc_wdata    = (state_reg == S_IDLE) ? write_data : wdata_reg;
  assign acc_idx      = acc_addr[RAM_AW-1:0];
  assign acc_in_range = (acc_addr[ADDR_W-1:RAM_AW] == '0);
  assign acc_known    = (acc_cmd == MREAD) || (acc_cmd == MWRITE);
  assign enter_resp   = (state_next == S_RESP);
  assign ram_we       = reset_n && enter_resp && (acc_cmd == MWRITE) && acc_in_range;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (mem_req) begin
          state_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
          cnt_next   = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0) state_next = S_RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      cmd_reg   <= 2'b00;
      addr_reg  <= '0;
      wdata_reg <= '0;
      data_out  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        cmd_reg   <= mem_cmd;
        addr_reg  <= mem_addr;
        wdata_reg <= write_data;
      end
      if (enter_resp && (acc_cmd == MREAD))
        data_out <= acc_in_range ? ram[acc_idx] : '0;
    end
  end

  // Memory contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[acc_idx] <= acc_wdata;
  end

  assign mem_ready = (state_reg == S_RESP);
  assign busy      = (state_reg != S_IDLE);

`ifdef MEM_CTRL_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_err <= 1'b0;
    else          mem_err <= enter_resp && (!acc_known || !acc_in_range);
  end
`else
  logic unused_known;
  assign unused_known = acc_known;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl: one default instance plus wait-state sweep instances.
module tb_mem_ctrl;

  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;
  localparam logic [1:0] UNK = 2'b11;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [1:0]  cmd_s;
  logic [8:0]  addr_s;
  logic [15:0] wdata_s;
  logic [3:0]  rdy;
  logic [3:0]  bsy;
  logic [15:0] dout [4];
`ifdef MEM_CTRL_ERR_EN
  logic [3:0]  errv;
  logic        last_err;
`endif

  int checks = 0;
  int errors = 0;
  int lat;
  logic busy_ok;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl #(.WAIT_STATES(1)) dut (
    .clk(clk), .reset_n(reset_n), .mem_req(req[0]), .mem_cmd(cmd_s), .mem_addr(addr_s),
    .write_data(wdata_s), .mem_ready(rdy[0]), .data_out(dout[0]), .busy(bsy[0])
`ifdef MEM_CTRL_ERR_EN
    , .mem_err(errv[0])
`endif
  );

  mem_ctrl #(.WAIT_STATES(0)) dut_w0 (
    .clk(clk), .reset_n(reset_n), .mem_req(req[1]), .mem_cmd(cmd_s), .mem_addr(addr_s),
    .write_data(wdata_s), .mem_ready(rdy[1]), .data_out(dout[1]), .busy(bsy[1])
`ifdef MEM_CTRL_ERR_EN
    , .mem_err(errv[1])
`endif
  );

  mem_ctrl #(.WAIT_STATES(3)) dut_w3 (
    .clk(clk), .reset_n(reset_n), .mem_req(req[2]), .mem_cmd(cmd_s), .mem_addr(addr_s),
    .write_data(wdata_s), .mem_ready(rdy[2]), .data_out(dout[2]), .busy(bsy[2])
`ifdef MEM_CTRL_ERR_EN
    , .mem_err(errv[2])
`endif
  );

  mem_ctrl #(.WAIT_STATES(15)) dut_w15 (
    .clk(clk), .reset_n(reset_n), .mem_req(req[3]), .mem_cmd(cmd_s), .mem_addr(addr_s),
    .write_data(wdata_s), .mem_ready(rdy[3]), .data_out(dout[3]), .busy(bsy[3])
`ifdef MEM_CTRL_ERR_EN
    , .mem_err(errv[3])
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Latency = number of edges from the sampling edge to the edge that sees mem_ready high.
  task automatic access(input int inst, input logic [1:0] cmd, input logic [8:0] addr,
                        input logic [15:0] wd, output int l, output logic bok);
    @(negedge clk);
    cmd_s = cmd; addr_s = addr; wdata_s = wd; req[inst] = 1'b1;
    @(posedge clk);
    #1 req[inst] = 1'b0;
    l = 99;
    bok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!bsy[inst]) bok = 1'b0;
      if (rdy[inst]) begin
        l = k;
`ifdef MEM_CTRL_ERR_EN
        last_err = errv[inst];
`endif
        break;
      end
    end
    $display("txn inst=%0d cmd=%b addr=%h wdata=%h latency=%0d data_out=%h",
             inst, cmd, addr, wd, l, dout[inst]);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req = 4'b0; cmd_s = 2'b00; addr_s = '0; wdata_s = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, rdy[0]}, 32'd0);
    chk("reset_busy",  {31'd0, bsy[0]}, 32'd0);
    chk("reset_dout",  {16'd0, dout[0]}, 32'd0);
    @(negedge clk) reset_n = 1'b1;

    // Establish old contents, then abort a write with reset mid-WAIT.
    access(0, WR, 9'h010, 16'h1111, lat, busy_ok);
    chk("wr_latency", lat, 32'd2);
    access(0, RD, 9'h010, 16'h0000, lat, busy_ok);
    chk("rd_old_0x010", {16'd0, dout[0]}, 32'h1111);
    @(negedge clk);
    cmd_s = WR; addr_s = 9'h010; wdata_s = 16'hBEEF; req[0] = 1'b1;
    @(posedge clk);
    #1 req[0] = 1'b0;
    chk("accepted_busy", {31'd0, bsy[0]}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, rdy[0]}, 32'd0);
    chk("midrst_busy",  {31'd0, bsy[0]}, 32'd0);
    chk("midrst_dout",  {16'd0, dout[0]}, 32'd0);
    @(posedge clk);
    #1 chk("midrst_ready_edge", {31'd0, rdy[0]}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    access(0, RD, 9'h010, 16'h0000, lat, busy_ok);
    chk("rd_after_abort", {16'd0, dout[0]}, 32'h1111);

    // Basic write then read.
    access(0, WR, 9'h042, 16'hABCD, lat, busy_ok);
    access(0, RD, 9'h042, 16'h0000, lat, busy_ok);
    chk("rd_0x042", {16'd0, dout[0]}, 32'hABCD);
    chk("rd_latency", lat, 32'd2);
    chk("rd_busy", {31'd0, busy_ok}, 32'd1);

    // Out-of-range accesses.
    access(0, WR, 9'h142, 16'h1234, lat, busy_ok);
    chk("oor_wr_latency", lat, 32'd2);
`ifdef MEM_CTRL_ERR_EN
    chk("oor_wr_err", {31'd0, last_err}, 32'd1);
`endif
    access(0, RD, 9'h042, 16'h0000, lat, busy_ok);
    chk("oor_wr_dropped", {16'd0, dout[0]}, 32'hABCD);
`ifdef MEM_CTRL_ERR_EN
    chk("inrange_no_err", {31'd0, last_err}, 32'd0);
`endif
    access(0, RD, 9'h1FF, 16'h0000, lat, busy_ok);
    chk("oor_rd_zero", {16'd0, dout[0]}, 32'h0000);
`ifdef MEM_CTRL_ERR_EN
    chk("oor_rd_err", {31'd0, last_err}, 32'd1);
`endif

    // Unknown command: completes, holds data_out, leaves RAM alone.
    access(0, RD, 9'h042, 16'h0000, lat, busy_ok);
    access(0, UNK, 9'h042, 16'h5555, lat, busy_ok);
    chk("unk_latency", lat, 32'd2);
    chk("unk_hold_dout", {16'd0, dout[0]}, 32'hABCD);
`ifdef MEM_CTRL_ERR_EN
    chk("unk_err", {31'd0, last_err}, 32'd1);
`endif
    access(1, WR, 9'h042, 16'h0000, lat, busy_ok);
    access(0, RD, 9'h000, 16'h0000, lat, busy_ok);
    access(0, RD, 9'h042, 16'h0000, lat, busy_ok);
    chk("unk_ram_unchanged", {16'd0, dout[0]}, 32'hABCD);

    // Input stability with mem_req held through RESP.
    access(0, WR, 9'h021, 16'h0001, lat, busy_ok);
    @(negedge clk);
    cmd_s = WR; addr_s = 9'h020; wdata_s = 16'h7777; req[0] = 1'b1;
    @(posedge clk);
    lat = 99;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rdy[0]) begin lat = k; break; end
      if (k % 2 == 1) begin cmd_s = WR; addr_s = 9'h021; wdata_s = 16'hDEAD; end
      else            begin cmd_s = RD; addr_s = 9'h022; wdata_s = 16'hAAAA; end
    end
    chk("stab_latency", lat, 32'd2);
    cmd_s = RD; addr_s = 9'h020; wdata_s = 16'h0000;
    @(negedge clk);
    chk("held_req_idle_busy",  {31'd0, bsy[0]}, 32'd0);
    chk("held_req_idle_ready", {31'd0, rdy[0]}, 32'd0);
    @(negedge clk);
    chk("held_req_reaccept", {31'd0, bsy[0]}, 32'd1);
    req[0] = 1'b0;
    lat = 99;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rdy[0]) begin lat = k; break; end
    end
    chk("second_rd_ready", lat, 32'd1);
    chk("stab_written", {16'd0, dout[0]}, 32'h7777);
    $display("txn inst=0 held-request read addr=020 data_out=%h", dout[0]);
    @(posedge clk);
    access(0, RD, 9'h021, 16'h0000, lat, busy_ok);
    chk("stab_no_stray_write", {16'd0, dout[0]}, 32'h0001);

    // Wait-state sweep.
    access(1, WR, 9'h031, 16'hC001, lat, busy_ok);
    access(1, RD, 9'h031, 16'h0000, lat, busy_ok);
    chk("ws0_latency", lat, 32'd1);
    chk("ws0_busy", {31'd0, busy_ok}, 32'd1);
    chk("ws0_data", {16'd0, dout[1]}, 32'hC001);
    access(2, WR, 9'h032, 16'hC003, lat, busy_ok);
    access(2, RD, 9'h032, 16'h0000, lat, busy_ok);
    chk("ws3_latency", lat, 32'd4);
    chk("ws3_busy", {31'd0, busy_ok}, 32'd1);
    chk("ws3_data", {16'd0, dout[2]}, 32'hC003);
    access(3, WR, 9'h033, 16'hC00F, lat, busy_ok);
    access(3, RD, 9'h033, 16'h0000, lat, busy_ok);
    chk("ws15_latency", lat, 32'd16);
    chk("ws15_busy", {31'd0, busy_ok}, 32'd1);
    chk("ws15_data", {16'd0, dout[3]}, 32'hC00F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
